// File: rtl/gamepad_serial_rx_pkg.sv
// Shared types and constants for the SNES-style gamepad receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gamepad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } gp_state_t;

    localparam int DEF_NBITS = 16;

    // Serial bit positions of the SNES buttons
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // A real pad always reports these bits released (high)
    localparam int PRES_LO = 12;
    localparam int PRES_HI = 15;

endpackage

// File: rtl/gamepad_serial_rx_if.sv
// Pad pins plus the decoded button bus of the gamepad receiver.
// Latency: n/a (wiring only).
// Backpressure: none; the frame pulse is fire-and-forget.
interface gamepad_serial_rx_if
    import gamepad_pkg::*;
#(
    parameter int NBITS = DEF_NBITS
);
    logic             pad_data_i;
    logic             pad_latch_o;
    logic             pad_clk_o;
    logic [NBITS-1:0] buttons_o;
    logic             frame_valid_o;
    logic             pad_present_o;

    // Receiver side
    modport master (
        input  pad_data_i,
        output pad_latch_o, pad_clk_o, buttons_o, frame_valid_o, pad_present_o
    );

    // Pad / consumer side
    modport slave (
        output pad_data_i,
        input  pad_latch_o, pad_clk_o, buttons_o, frame_valid_o, pad_present_o
    );
endinterface

// File: rtl/gamepad_serial_rx_sync2.sv
// Two-flop synchronizer for the asynchronous pad data line.
// Latency: 2 clk cycles.
// Backpressure: none.
module gamepad_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Double-register the async input to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/gamepad_serial_rx.sv
// Polls an SNES pad (latch + NBITS clocked bits) every POLL_PER cycles; GAMEPAD_DEBOUNCE_EN gates updates on two equal frames.
// Latency: frame = 2*HALF_PER*(NBITS+1) cycles after the poll, plus one DONE cycle where outputs update.
// Backpressure: none; one poll request queues while busy, further ones are dropped.
module gamepad_serial_rx
    import gamepad_pkg::*;
#(
    parameter int HALF_PER = 300,
    parameter int POLL_PER = 833333,
    parameter int NBITS    = DEF_NBITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gamepad_serial_rx_if.master  bus
);
    localparam int PH_W  = $clog2(2*HALF_PER + 1);
    localparam int TMR_W = $clog2(POLL_PER + 1);
    localparam int IDX_W = $clog2(NBITS);

    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_PER - 1);
    localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2*HALF_PER - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NBITS - 1);

    gp_state_t        state_q;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [PH_W-1:0]  ph_q;
    logic [IDX_W-1:0] idx_q;
    logic [NBITS-1:0] shreg_q;
    logic             pend_q;
    logic             latch_q;
    logic             pclk_q;
    logic [NBITS-1:0] btn_q;
    logic             fv_q;
    logic             pres_q;
`ifdef GAMEPAD_DEBOUNCE_EN
    logic [NBITS-1:0] prev_q;
`endif

    logic data_sync;
    logic poll_req;
    logic present;

    gamepad_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.pad_data_i),
        .q_o   (data_sync)
    );

    assign timer_d  = (timer_q == TMR_LAST) ? '0 : timer_q + TMR_W'(1);
    assign poll_req = (timer_q == TMR_LAST);
    assign present  = &shreg_q[PRES_HI:PRES_LO];

    // Free-running poll timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end

    // Frame sequencer with registered pad pins and button outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            pend_q  <= 1'b0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
            btn_q   <= '0;
            fv_q    <= 1'b0;
            pres_q  <= 1'b0;
`ifdef GAMEPAD_DEBOUNCE_EN
            prev_q  <= '0;
`endif
        end else begin
            fv_q <= 1'b0;
            // A request seen mid-frame is remembered once; start states override below
            if (poll_req) pend_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (poll_req || pend_q) begin
                        state_q <= ST_LATCH;
                        latch_q <= 1'b1;
                        ph_q    <= '0;
                        pend_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LATCH: begin
                    if (ph_q == LATCH_LAST) begin
                        state_q <= ST_LOW;
                        latch_q <= 1'b0;
                        pclk_q  <= 1'b0;
                        ph_q    <= '0;
                        idx_q   <= '0;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                ST_LOW: begin
                    if (ph_q == HALF_LAST) begin
                        shreg_q[idx_q] <= data_sync;
                        state_q        <= ST_HIGH;
                        pclk_q         <= 1'b1;
                        ph_q           <= '0;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (ph_q == HALF_LAST) begin
                        ph_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_DONE;
                            fv_q    <= 1'b1;
`ifdef GAMEPAD_DEBOUNCE_EN
                            prev_q <= shreg_q;
                            if (shreg_q == prev_q) begin
                                pres_q <= present;
                                btn_q  <= present ? ~shreg_q : '0;
                            end
`else
                            pres_q <= present;
                            btn_q  <= present ? ~shreg_q : '0;
`endif
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_LOW;
                            pclk_q  <= 1'b0;
                        end
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.pad_latch_o   = latch_q;
    assign bus.pad_clk_o     = pclk_q;
    assign bus.buttons_o     = btn_q;
    assign bus.frame_valid_o = fv_q;
    assign bus.pad_present_o = pres_q;
endmodule

// File: tb/tb_gamepad_serial_rx.sv
// Bench for gamepad_serial_rx: two instances (POLL_PER 200 and 100) against a timeline model.
module tb_gamepad_serial_rx;
    import gamepad_pkg::*;

    localparam int HP    = 4;
    localparam int NB    = 16;
    localparam int FRAME = 2*HP + NB*2*HP;   // cycles of latch + bits; DONE follows

`ifdef GAMEPAD_DEBOUNCE_EN
    localparam logic [15:0] SEQ_BTN [4] = '{16'h0000, 16'h0001, 16'h0001, 16'h0002};
`else
    localparam logic [15:0] SEQ_BTN [4] = '{16'h0001, 16'h0001, 16'h0002, 16'h0002};
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] raw_word = 16'hFFFE;
    logic        tie0     = 1'b0;

    gamepad_serial_rx_if #(.NBITS(16)) bus0 ();
    gamepad_serial_rx_if #(.NBITS(16)) bus1 ();

    gamepad_serial_rx #(.HALF_PER(HP), .POLL_PER(200), .NBITS(NB)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master));
    gamepad_serial_rx #(.HALF_PER(HP), .POLL_PER(100), .NBITS(NB)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master));

    // Cycle n = state after the n-th rising edge since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Model state per instance
    int          poll  [2] = '{200, 100};
    bit          act   [2];
    int          st    [2];
    bit          pend  [2];
    logic [15:0] word  [2];
    logic [15:0] mbtn  [2];
    logic        mpres [2];
    logic [15:0] prev  [2];
    int          pidx  [2];
    logic        pclk_prev [2] = '{1'b1, 1'b1};

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, got, exp);
        end
    endtask

    task automatic step(input int k, input logic latch, input logic pclk, input logic fv,
                        input logic pres, input logic [15:0] btn, output logic pd);
        int d;
        bit req, e_latch, e_clk, e_fv, present;
        logic [15:0] raw;
        if (!rst_n) begin
            act[k] = 0; pend[k] = 0; mbtn[k] = '0; mpres[k] = 1'b0; prev[k] = '0;
            chk("rst_latch", k, latch, 0);
            chk("rst_clk", k, pclk, 1);
            chk("rst_fv", k, fv, 0);
            chk("rst_pres", k, pres, 0);
            chk("rst_btn", k, btn, 0);
        end else begin
            req = (cyc > 0) && (cyc % poll[k] == 0);
            if ((!act[k] || cyc >= st[k] + FRAME + 1) && (req || pend[k])) begin
                act[k] = 1; st[k] = cyc; pend[k] = 0;
                word[k] = tie0 ? 16'h0000 : raw_word;
            end else if (req) begin
                pend[k] = 1;
            end
            d = cyc - st[k];
            e_latch = act[k] && d < 2*HP;
            e_clk   = !(act[k] && d >= 2*HP && d < FRAME && ((d - 2*HP) % (2*HP)) < HP);
            e_fv    = act[k] && d == FRAME;
            if (e_fv) begin
                raw = word[k];
                present = (raw[15:12] == 4'hF);
`ifdef GAMEPAD_DEBOUNCE_EN
                if (raw == prev[k]) begin
                    mpres[k] = present;
                    mbtn[k]  = present ? ~raw : 16'h0000;
                end
                prev[k] = raw;
`else
                mpres[k] = present;
                mbtn[k]  = present ? ~raw : 16'h0000;
`endif
            end
            chk("latch", k, latch, e_latch);
            chk("pad_clk", k, pclk, e_clk);
            chk("frame_valid", k, fv, e_fv);
            chk("present", k, pres, mpres[k]);
            chk("buttons", k, btn, mbtn[k]);
        end
        // Pad behaviour: latch reloads bit 0, each pad_clk rise advances
        if (latch) pidx[k] = 0;
        else if (pclk && !pclk_prev[k]) pidx[k]++;
        pclk_prev[k] = pclk;
        pd = (pidx[k] < 16) ? word[k][pidx[k]] : word[k][15];
    endtask

    // Compare process: every cycle, away from the active edge
    always @(posedge clk) begin
        logic pd;
        #1;
        step(0, bus0.pad_latch_o, bus0.pad_clk_o, bus0.frame_valid_o, bus0.pad_present_o, bus0.buttons_o, pd);
        bus0.pad_data_i = pd;
        step(1, bus1.pad_latch_o, bus1.pad_clk_o, bus1.frame_valid_o, bus1.pad_present_o, bus1.buttons_o, pd);
        bus1.pad_data_i = pd;
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 5000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (cyc != n) begin
            fails++;
            tests++;
            $display("FAIL wait_cyc: reached %0d expected %0d", cyc, n);
        end
    endtask

    initial begin
        bus0.pad_data_i = 1'b0;
        bus1.pad_data_i = 1'b0;
        word[0] = '0; word[1] = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("lit_rst_clk", 0, bus0.pad_clk_o, 1);
        chk("lit_rst_btn", 0, bus0.buttons_o, 0);
        @(negedge clk) rst_n = 1'b1;

        // First latch pulse and first clock pulse
        wait_cyc(199); chk("lit_latch199", 0, bus0.pad_latch_o, 0);
        wait_cyc(200); chk("lit_latch200", 0, bus0.pad_latch_o, 1);
        wait_cyc(207); chk("lit_latch207", 0, bus0.pad_latch_o, 1);
                       chk("lit_clk207", 0, bus0.pad_clk_o, 1);
        wait_cyc(208); chk("lit_latch208", 0, bus0.pad_latch_o, 0);
                       chk("lit_clk208", 0, bus0.pad_clk_o, 0);
        wait_cyc(211); chk("lit_clk211", 0, bus0.pad_clk_o, 0);
        wait_cyc(212); chk("lit_clk212", 0, bus0.pad_clk_o, 1);
        // Fast instance: held request starts LATCH right after DONE
        wait_cyc(236); chk("lit_fv236", 1, bus1.frame_valid_o, 1);
        wait_cyc(237); chk("lit_latch237", 1, bus1.pad_latch_o, 1);
        wait_cyc(336); chk("lit_fv336", 0, bus0.frame_valid_o, 1);
        wait_cyc(337); chk("lit_seq0", 0, bus0.buttons_o, SEQ_BTN[0]);
                       chk("lit_fv337", 0, bus0.frame_valid_o, 0);
        wait_cyc(373); chk("lit_fv373", 1, bus1.frame_valid_o, 1);
        wait_cyc(374); chk("lit_latch374", 1, bus1.pad_latch_o, 1);
        wait_cyc(500); raw_word = 16'hFFFD;
        wait_cyc(537); chk("lit_seq1", 0, bus0.buttons_o, SEQ_BTN[1]);
                       chk("lit_pres537", 0, bus0.pad_present_o, 1);
        wait_cyc(737); chk("lit_seq2", 0, bus0.buttons_o, SEQ_BTN[2]);
        wait_cyc(937); chk("lit_seq3", 0, bus0.buttons_o, SEQ_BTN[3]);

        // Absent pad: data line held low
        wait_cyc(950); tie0 = 1'b1;
        wait_cyc(1336); chk("lit_fv_absent", 0, bus0.frame_valid_o, 1);
        wait_cyc(1337); chk("lit_btn_absent", 0, bus0.buttons_o, 0);
                        chk("lit_pres_absent", 0, bus0.pad_present_o, 0);
        wait_cyc(1400); tie0 = 1'b0;

        // Randomized frames, some repeated to exercise equal-frame updates
        for (int n = 1550; n <= 2650; n += 150) begin
            wait_cyc(n);
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 1) != 0) raw_word = {4'hF, 12'($urandom)};
                else                           raw_word = 16'($urandom);
            end
        end
        wait_cyc(2700); raw_word = 16'hF0A5;
        wait_cyc(3137); chk("lit_btn_f0a5", 0, bus0.buttons_o, 16'h0F5A);
                        chk("lit_pres_f0a5", 0, bus0.pad_present_o, 1);

        // Reset during bit 7 low phase
        wait_cyc(3265); chk("lit_bit7_low", 0, bus0.pad_clk_o, 0);
        rst_n = 1'b0;
        #1;
        chk("lit_mid_clk", 0, bus0.pad_clk_o, 1);
        chk("lit_mid_latch", 0, bus0.pad_latch_o, 0);
        chk("lit_mid_btn", 0, bus0.buttons_o, 0);
        chk("lit_mid_pres", 0, bus0.pad_present_o, 0);
        chk("lit_mid_clk", 1, bus1.pad_clk_o, 1);
        chk("lit_mid_btn", 1, bus1.buttons_o, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_cyc(199); chk("lit_re_latch199", 0, bus0.pad_latch_o, 0);
        wait_cyc(200); chk("lit_re_latch200", 0, bus0.pad_latch_o, 1);
        wait_cyc(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gamepad_serial_rx.md
# gamepad_serial_rx

Polling receiver for an SNES-style serial gamepad; it is the input stage upstream of the gamepad top level (`tt_um_angel_gamepad`). At a fixed poll rate it drives the pad's latch and clock lines and shifts in the serial data bits. It then presents a registered, active-high button vector with a frame-valid pulse and a controller-present flag.

## Interface
- `HALF_PER`, default 300: `pad_clk_o` half-period in `clk` cycles; must be ≥ 4. The default gives 6 µs at 50 MHz.
- `POLL_PER`, default 833333: poll interval in `clk` cycles (60 Hz at 50 MHz).
- `NBITS`, default 16: serial bits per frame; must be ≥ 16.
- `clk` in 1: single clock; all logic in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pad_data_i` in 1: raw serial data from the pad (low = pressed); asynchronous.
- `pad_latch_o` out 1: latch strobe to the pad, active high.
- `pad_clk_o` out 1: shift clock to the pad; idles high.
- `buttons_o` out NBITS: button state; bit i = serial bit i inverted (1 = pressed).
- `frame_valid_o` out 1: one-cycle pulse when a frame completes.
- `pad_present_o` out 1: a genuine controller was detected in the last frame.

## Operation
- `pad_data_i` passes through a 2-flop synchronizer before use.
- Poll timer:
  - Free-running counter, 0..POLL_PER-1, wraps.
  - Raises a poll request at count POLL_PER-1.
  - A request arriving while the FSM is busy is held as a single pending request. Extra requests are dropped.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE.
  - IDLE: `pad_clk_o`=1, `pad_latch_o`=0. A pending request moves to LATCH and clears the request.
  - LATCH: `pad_latch_o`=1 for 2·HALF_PER cycles, then LOW with bit index = 0.
  - LOW: `pad_clk_o`=0 for HALF_PER cycles. On the last cycle, the synchronized data bit is stored into shift register position [index]. Then go to HIGH.
  - HIGH: `pad_clk_o`=1 for HALF_PER cycles. The rising edge makes the pad advance to the next bit. If index = NBITS-1, go to DONE; otherwise increment index and go to LOW.
  - DONE: one cycle. Outputs update, `frame_valid_o` pulses, return to IDLE.
- Presence check:
  - Presence = raw bits 12..15 all 1 (a genuine pad always reports these released).
  - The board pull-down makes an absent pad read all 0.
- Output update in DONE:
  - `pad_present_o` ← presence.
  - `buttons_o` ← ~raw if present, else 0.
- Counters are wide enough for 2·HALF_PER, POLL_PER and NBITS with no overflow. The index never exceeds NBITS-1.

## Timing
- Reset values: `pad_latch_o`=0, `pad_clk_o`=1, `buttons_o`=0, `frame_valid_o`=0, `pad_present_o`=0. Timer, index, shift register, synchronizer and pending request all reset to 0.
- The first poll request is raised POLL_PER cycles after `rst_n` deasserts. `pad_latch_o` rises on the next cycle.
- Frame length:
  - LATCH + bits = 2·HALF_PER + NBITS·2·HALF_PER cycles, then 1 DONE cycle.
  - `buttons_o` changes in the same cycle that `frame_valid_o` is high.
- Synchronizer latency is 2 cycles, which is ≪ HALF_PER, so sampling at the end of LOW sees settled data.
- If POLL_PER ≤ frame length, frames run back-to-back: LATCH starts the cycle after DONE.
- Reset asserted mid-frame: all outputs return immediately (asynchronously) to their reset values. The partial frame is discarded.

## Configuration
- `GAMEPAD_DEBOUNCE_EN` defined:
  - The previous frame's raw word is kept in a register.
  - `buttons_o`/`pad_present_o` update only when the current raw frame equals the previous one.
  - `frame_valid_o` still pulses every frame.
- Undefined: outputs update on every frame; no previous-frame register exists.

## Structure
- `gamepad_pkg` holds:
  - The FSM state enum.
  - Default NBITS.
  - SNES bit-index constants: B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11.
  - The presence-bit range 12..15.
- One sub-module, `gamepad_sync2`: the 2-flop synchronizer with async active-low reset.

## Test plan
Bench uses HALF_PER=4, POLL_PER=200 (frame = 136 + 1 cycles).
- Reset release → outputs at reset values. `pad_latch_o` high 8 cycles starting cycle 200. Then 16 low pulses on `pad_clk_o`, each 4 cycles low / 4 cycles high.
- Pad model sends raw 0xFFFE → `buttons_o`=0x0001, `pad_present_o`=1, exactly one `frame_valid_o` pulse per frame.
- `pad_data_i` tied 0 → `pad_present_o`=0, `buttons_o`=0x0000, `frame_valid_o` still pulses.
- `rst_n` low during bit 7 LOW phase → `pad_clk_o`=1, `pad_latch_o`=0, `buttons_o`=0 immediately. After release, the next latch comes at cycle 200.
- With `GAMEPAD_DEBOUNCE_EN`, raw frames 0xFFFE, 0xFFFE, 0xFFFD, 0xFFFD → `buttons_o` = 0x0000, 0x0001, 0x0001, 0x0002. Without the macro → 0x0001, 0x0001, 0x0002, 0x0002.
- POLL_PER=100 → a pending request is held. The next `pad_latch_o` rises the cycle after DONE, and no request is lost or doubled.
